ddr3_arbiter: RTL and testbench

DDR3_ARBITER -- requirements
Module: ddr3_arbiter

---
 rtl/ddr3_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ddr3_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_arbiter.sv
// Three-port round-robin arbiter in front of a single ddr3_dev request/ack port.
// One transaction at a time: IDLE -> GRANT (wait for mem_ack_i) -> RESP (ack pulse).
module ddr3_arbiter #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_data_i,
   input  logic        p0_rd_i,
   input  logic        p0_we_i,
   output logic        p0_ack_o,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_data_i,
   input  logic        p1_rd_i,
   input  logic        p1_we_i,
   output logic        p1_ack_o,
   input  logic [31:0] p2_addr_i,
   input  logic [31:0] p2_data_i,
   input  logic        p2_rd_i,
   input  logic        p2_we_i,
   output logic        p2_ack_o,
   output logic [31:0] rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_rd_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   output logic        err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  sel_q, sel_d;
   logic        rd_op_q, rd_op_d;
   logic        oor_q, oor_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_we_q, mem_we_d;
   logic [2:0]  ack_q, ack_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic [2:0]  req;
   logic [2:0]  cand;
   logic [1:0]  win;
   logic        found;
   logic [31:0] win_addr, win_data;
   logic        win_rd, win_in_range;

   assign req = {p2_rd_i | p2_we_i, p1_rd_i | p1_we_i, p0_rd_i | p0_we_i};

   // Round-robin search starting one past the last winner.
   always_comb begin
      cand  = 3'd0;
      win   = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cand = {1'b0, last_q} + 3'd1 + 3'(i);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!found && req[cand[1:0]]) begin
            found = 1'b1;
            win   = cand[1:0];
         end
      end
   end

   // rd has priority over we when both are raised.
   always_comb begin
      case (win)
         2'd1:    begin win_addr = p1_addr_i; win_data = p1_data_i; win_rd = p1_rd_i; end
         2'd2:    begin win_addr = p2_addr_i; win_data = p2_data_i; win_rd = p2_rd_i; end
         default: begin win_addr = p0_addr_i; win_data = p0_data_i; win_rd = p0_rd_i; end
      endcase
      win_in_range = (win_addr[31:29] == 3'b000);
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      sel_d    = sel_q;
      rd_op_d  = rd_op_q;
      oor_d    = oor_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      mem_rd_d = mem_rd_q;
      mem_we_d = mem_we_q;
      ack_d    = 3'b000;
      err_d    = err_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d  = GRANT;
               last_d   = win;
               sel_d    = win;
               rd_op_d  = win_rd;
               oor_d    = !win_in_range;
               addr_d   = win_addr;
               wdata_d  = win_data;
               mem_rd_d = win_rd & win_in_range;
               mem_we_d = !win_rd & win_in_range;
               cnt_d    = 16'd0;
            end
         end
         GRANT: begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (oor_q) begin
               // Out-of-range bypass: never touches the device.
               state_d = RESP;
               err_d   = 1'b1;
               ack_d   = 3'b001 << sel_q;
               if (rd_op_q) rdata_d = 32'd0;
            end else if (mem_ack_i) begin
               state_d  = RESP;
               mem_rd_d = 1'b0;
               mem_we_d = 1'b0;
               ack_d    = 3'b001 << sel_q;
               if (rd_op_q) rdata_d = mem_data_i;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               err_d = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= 2'd2;
         sel_q    <= 2'd0;
         rd_op_q  <= 1'b0;
         oor_q    <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         mem_rd_q <= 1'b0;
         mem_we_q <= 1'b0;
         ack_q    <= 3'b000;
         err_q    <= 1'b0;
         cnt_q    <= 16'd0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         rd_op_q  <= rd_op_d;
         oor_q    <= oor_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         mem_rd_q <= mem_rd_d;
         mem_we_q <= mem_we_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign p0_ack_o   = ack_q[0];
   assign p1_ack_o   = ack_q[1];
   assign p2_ack_o   = ack_q[2];
   assign rdata_o    = rdata_q;
   assign mem_addr_o = addr_q;
   assign mem_data_o = wdata_q;
   assign mem_rd_o   = mem_rd_q;
   assign mem_we_o   = mem_we_q;
   assign err_o      = err_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Transaction-level bench for ddr3_arbiter: requesters and the memory responder are
// driven from tables/random draws, and each grant is predicted from the round-robin rule.
module tb_ddr3_arbiter;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req_addr [3];
   logic [31:0] req_data [3];
   logic [2:0]  req_rd, req_we;
   logic [2:0]  acks;
   logic [31:0] rdata_o, mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_rd_o, mem_we_o, mem_ack_i, err_o, busy_o;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          last_g;
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic [1:0]  exp_q[$];

   ddr3_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_addr_i(req_addr[0]), .p0_data_i(req_data[0]), .p0_rd_i(req_rd[0]), .p0_we_i(req_we[0]), .p0_ack_o(acks[0]),
      .p1_addr_i(req_addr[1]), .p1_data_i(req_data[1]), .p1_rd_i(req_rd[1]), .p1_we_i(req_we[1]), .p1_ack_o(acks[1]),
      .p2_addr_i(req_addr[2]), .p2_data_i(req_data[2]), .p2_rd_i(req_rd[2]), .p2_we_i(req_we[2]), .p2_ack_o(acks[2]),
      .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_rd_o(mem_rd_o), .mem_we_o(mem_we_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .err_o(err_o), .busy_o(busy_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Spec rule: search from last grant + 1 (mod 3), first requester wins.
   function automatic int rr_pick();
      for (int i = 1; i <= 3; i++) begin
         int p = (last_g + i) % 3;
         if (req_rd[p] | req_we[p]) return p;
      end
      return -1;
   endfunction

   // ---------------- drivers ----------------
   task automatic set_req(input int p, input logic rd, input logic we, input logic [31:0] a, input logic [31:0] d);
      req_rd[p]   = rd;
      req_we[p]   = we;
      req_addr[p] = a;
      req_data[p] = d;
   endtask

   task automatic new_req(input int p);
      logic rd, we;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      we = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 9) == 0) a = {3'($urandom_range(1, 7)), 29'($urandom)};
      else a = {3'b000, 29'($urandom)};
      set_req(p, rd, we, a, $urandom);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
      check({tag, "_acks"},  {29'd0, acks}, 32'd0);
      check({tag, "_memop"}, {30'd0, mem_rd_o, mem_we_o}, 32'd0);
      check({tag, "_rdata"}, rdata_o, exp_rdata);
      check({tag, "_err"},   {31'd0, err_o}, {31'd0, exp_err});
   endtask

   task automatic check_reset_outputs();
      check("rst_acks",  {29'd0, acks}, 32'd0);
      check("rst_memop", {30'd0, mem_rd_o, mem_we_o}, 32'd0);
      check("rst_addr",  mem_addr_o, 32'd0);
      check("rst_data",  mem_data_o, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_err",   {31'd0, err_o}, 32'd0);
      check("rst_busy",  {31'd0, busy_o}, 32'd0);
   endtask

   // Called mid-cycle; asserts reset asynchronously, releases just after an edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      step();
      step();
      rst_n     = 1'b1;
      mem_ack_i = 1'b0;
      last_g    = 2;
      exp_rdata = 32'd0;
      exp_err   = 1'b0;
      exp_q.delete();
   endtask

   // Entered in an IDLE cycle with at least one request; returns in the following IDLE cycle.
   task automatic run_txn(input int delay, input logic [31:0] ack_data, input bit renew);
      int w;
      logic is_rd, oor;
      logic [31:0] a, d, got;
      w = rr_pick();
      if (w < 0) return;
      check_idle("idle");
      is_rd = req_rd[w];
      a     = req_addr[w];
      d     = req_data[w];
      oor   = (a[31:29] != 3'b000);
      exp_q.push_back(2'(w));
      last_g = w;
      step();
      if (oor) begin
         check("byp_busy",  {31'd0, busy_o}, 32'd1);
         check("byp_memop", {30'd0, mem_rd_o, mem_we_o}, 32'd0);
         check("byp_acks",  {29'd0, acks}, 32'd0);
         req_addr[w] = $urandom;
         step();
         exp_err = 1'b1;
         if (is_rd) exp_rdata = 32'd0;
      end else begin
         got = 32'd0;
         for (int k = 1; k <= delay + 1; k++) begin
            check("gr_busy",  {31'd0, busy_o}, 32'd1);
            check("gr_rd",    {31'd0, mem_rd_o}, {31'd0, is_rd});
            check("gr_we",    {31'd0, mem_we_o}, {31'd0, !is_rd});
            check("gr_addr",  mem_addr_o, a);
            check("gr_wdata", mem_data_o, d);
            check("gr_acks",  {29'd0, acks}, 32'd0);
            check("gr_err",   {31'd0, err_o}, {31'd0, exp_err | (k > TIMEOUT)});
            req_addr[w] = $urandom;
            req_data[w] = $urandom;
            mem_ack_i   = (k == delay + 1);
            mem_data_i  = (k == delay + 1) ? ack_data : $urandom;
            got         = mem_data_i;
            step();
         end
         mem_ack_i = 1'b0;
         mem_data_i = $urandom;
         if (delay >= TIMEOUT) exp_err = 1'b1;
         if (is_rd) exp_rdata = got;
      end
      check("resp_ack",   {29'd0, acks}, {29'd0, 3'b001 << exp_q.pop_front()});
      check("resp_memop", {30'd0, mem_rd_o, mem_we_o}, 32'd0);
      check("resp_busy",  {31'd0, busy_o}, 32'd1);
      check("resp_rdata", rdata_o, exp_rdata);
      check("resp_err",   {31'd0, err_o}, {31'd0, exp_err});
      if (renew) new_req(w);
      else set_req(w, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n      = 1'b1;
      req_rd     = 3'b000;
      req_we     = 3'b000;
      mem_ack_i  = 1'b0;
      mem_data_i = 32'd0;
      for (int p = 0; p < 3; p++) set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
      last_g = 2; exp_rdata = 32'd0; exp_err = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs();
      step();
      step();
      rst_n = 1'b1;

      // Read with ack 5 cycles into GRANT.
      set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'd0);
      run_txn(5, 32'hDEAD_BEEF, 1'b0);
      check("p0_read_data", rdata_o, 32'hDEAD_BEEF);
      // Write leaves rdata alone.
      set_req(2, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
      run_txn(3, 32'hFFFF_FFFF, 1'b0);
      check("p2_write_keeps_rdata", rdata_o, 32'hDEAD_BEEF);
      // Timeout then a late ack.
      set_req(1, 1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
      run_txn(10, 32'd0, 1'b0);
      check("timeout_err", {31'd0, err_o}, 32'd1);
      do_reset();

      // Out-of-range read bypass.
      set_req(1, 1'b1, 1'b0, 32'h2000_0000, 32'd0);
      run_txn(0, 32'd0, 1'b0);
      check("oor_err", {31'd0, err_o}, 32'd1);
      do_reset();

      // All three ports requesting continuously.
      for (int p = 0; p < 3; p++) set_req(p, 1'b1, 1'b0, {3'b000, 29'($urandom)}, 32'd0);
      for (int t = 0; t < 6; t++) run_txn($urandom_range(0, 3), $urandom, 1'b1);

      // Reset mid-GRANT, then port 0 must win first.
      for (int p = 0; p < 3; p++) set_req(p, 1'b0, 1'b1, {3'b000, 29'($urandom)}, $urandom);
      step();
      check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      do_reset();
      run_txn(1, $urandom, 1'b1);

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         for (int p = 0; p < 3; p++)
            if (!(req_rd[p] | req_we[p]) && $urandom_range(0, 2) == 0) new_req(p);
         if (rr_pick() < 0) begin
            check_idle("quiet");
            step();
         end else begin
            run_txn(($urandom_range(0, 24) == 0) ? TIMEOUT + 1 : $urandom_range(0, 4),
                    $urandom, $urandom_range(0, 3) != 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
